pipeline_run_ctrl: RTL and testbench

//  Run-control sequencer for the 5-stage MIPS pipeline. Generates the global stage enable
//  (o_pipe_en) and supports continuous-run and single-step modes. Drains in-flight

---
 rtl/pipeline_run_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_run_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run-control sequencer for the 5-stage MIPS pipeline
module pipeline_run_ctrl #(
   parameter int CYCLE_BITS   = 32,
   parameter int DRAIN_CYCLES = 4,
   parameter int STATE_BITS   = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_cmd_run,
   input  logic                  i_cmd_step,
   input  logic                  i_cmd_stop,
   input  logic                  i_cmd_clear,
   input  logic                  i_HALT,
   input  logic                  i_pc_Write,
   input  logic                  i_IFID_Write,
   output logic                  o_pipe_en,
   output logic                  o_pc_Write,
   output logic                  o_IFID_Write,
   output logic                  o_step_ack,
   output logic                  o_done,
   output logic [STATE_BITS-1:0] o_state,
   output logic [CYCLE_BITS-1:0] o_cycle_count
);

   // Drain counter only needs to hold DRAIN_CYCLES down to 1.
   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [DW-1:0]         drain_q, drain_d;
   logic [CYCLE_BITS-1:0] count_q, count_d;
   logic                  step_ack_q, step_ack_d;
   logic                  pipe_en;

   // Enable is a pure decode of the state register, never of the command inputs.
   assign pipe_en = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

   // State, drain counter, cycle counter and step acknowledge registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         drain_q    <= '0;
         count_q    <= '0;
         step_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         count_q    <= count_d;
         step_ack_q <= step_ack_d;
      end
   end

   // Next-state decode: stop > run > step; HALT is only looked at while enabled.
   always_comb begin
      state_d    = state_q;
      drain_d    = drain_q;
      step_ack_d = (state_q == ST_STEP);
      case (state_q)
         ST_IDLE: begin
            if (i_cmd_run)       state_d = ST_RUN;
            else if (i_cmd_step) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (i_HALT) begin
               state_d = ST_DRAIN;
               drain_d = DW'(DRAIN_CYCLES);
            end else if (i_cmd_stop) begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (i_HALT) begin
               state_d = ST_DRAIN;
               drain_d = DW'(DRAIN_CYCLES);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - DW'(1);
            if (drain_q == DW'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (i_cmd_clear) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            drain_d = '0;
         end
      endcase
   end

   // Saturating count of enabled cycles; clear only honoured while parked.
   always_comb begin
      count_d = count_q;
      if (pipe_en && (count_q != {CYCLE_BITS{1'b1}})) count_d = count_q + CYCLE_BITS'(1);
      if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && i_cmd_clear) count_d = '0;
   end

   assign o_pipe_en     = pipe_en;
   assign o_pc_Write    = i_pc_Write & pipe_en & (state_q != ST_DRAIN);
   assign o_IFID_Write  = i_IFID_Write & pipe_en;
   assign o_step_ack    = step_ack_q;
   assign o_done        = (state_q == ST_DONE);
   assign o_state       = STATE_BITS'(state_q);
   assign o_cycle_count = count_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb/tb_pipeline_run_ctrl.sv - self-checking bench for pipeline_run_ctrl
module tb_pipeline_run_ctrl;

   localparam int DRAIN = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_DONE = 4;

   logic i_clk, i_reset;
   logic i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_HALT, i_pc_Write, i_IFID_Write;

   logic        o_pipe_en, o_pc_Write, o_IFID_Write, o_step_ack, o_done;
   logic [2:0]  o_state;
   logic [31:0] o_cycle_count;

   logic        s_pipe_en, s_pc_Write, s_IFID_Write, s_step_ack, s_done;
   logic [2:0]  s_state;
   logic [3:0]  s_cycle_count;

   pipeline_run_ctrl #(.CYCLE_BITS(32), .DRAIN_CYCLES(DRAIN), .STATE_BITS(3)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cmd_run(i_cmd_run), .i_cmd_step(i_cmd_step), .i_cmd_stop(i_cmd_stop),
      .i_cmd_clear(i_cmd_clear), .i_HALT(i_HALT),
      .i_pc_Write(i_pc_Write), .i_IFID_Write(i_IFID_Write),
      .o_pipe_en(o_pipe_en), .o_pc_Write(o_pc_Write), .o_IFID_Write(o_IFID_Write),
      .o_step_ack(o_step_ack), .o_done(o_done), .o_state(o_state),
      .o_cycle_count(o_cycle_count)
   );

   pipeline_run_ctrl #(.CYCLE_BITS(4), .DRAIN_CYCLES(DRAIN), .STATE_BITS(3)) dut_small (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cmd_run(i_cmd_run), .i_cmd_step(i_cmd_step), .i_cmd_stop(i_cmd_stop),
      .i_cmd_clear(i_cmd_clear), .i_HALT(i_HALT),
      .i_pc_Write(i_pc_Write), .i_IFID_Write(i_IFID_Write),
      .o_pipe_en(s_pipe_en), .o_pc_Write(s_pc_Write), .o_IFID_Write(s_IFID_Write),
      .o_step_ack(s_step_ack), .o_done(s_done), .o_state(s_state),
      .o_cycle_count(s_cycle_count)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int     n_vec = 0;
   int     n_err = 0;
   int     m_mode;
   int     m_left;
   longint m_count;
   bit     m_ack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit en;
      en = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
      chk("pipe_en",  64'(o_pipe_en),    64'(en));
      chk("pc_write", 64'(o_pc_Write),   64'(i_pc_Write && en && (m_mode != M_DRAIN)));
      chk("ifid_write", 64'(o_IFID_Write), 64'(i_IFID_Write && en));
      chk("step_ack", 64'(o_step_ack),   64'(m_ack));
      chk("done",     64'(o_done),       64'(m_mode == M_DONE));
      chk("state",    64'(o_state),      64'(m_mode));
      chk("count",    64'(o_cycle_count), 64'(m_count));
      chk("count4",   64'(s_cycle_count), 64'((m_count > 15) ? 15 : m_count));
      chk("state4",   64'(s_state),      64'(m_mode));
   endtask

   // Reference behaviour for one rising edge, written from the run-control rules.
   task automatic model_edge();
      bit en;
      en = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
      m_ack = (m_mode == M_STEP);
      if (en) m_count++;
      if (m_mode == M_IDLE) begin
         if (i_cmd_clear) m_count = 0;
         if (i_cmd_run) m_mode = M_RUN;
         else if (i_cmd_step) m_mode = M_STEP;
      end else if (m_mode == M_RUN) begin
         if (i_HALT) begin m_mode = M_DRAIN; m_left = DRAIN; end
         else if (i_cmd_stop) m_mode = M_IDLE;
      end else if (m_mode == M_STEP) begin
         if (i_HALT) begin m_mode = M_DRAIN; m_left = DRAIN; end
         else m_mode = M_IDLE;
      end else if (m_mode == M_DRAIN) begin
         m_left--;
         if (m_left == 0) m_mode = M_DONE;
      end else begin
         if (i_cmd_clear) begin m_mode = M_IDLE; m_count = 0; end
      end
   endtask

   task automatic cyc(input bit run = 0, input bit step = 0, input bit stop = 0,
                      input bit clear = 0, input bit halt = 0,
                      input bit pcw = 1, input bit ifw = 1);
      i_cmd_run = run; i_cmd_step = step; i_cmd_stop = stop; i_cmd_clear = clear;
      i_HALT = halt; i_pc_Write = pcw; i_IFID_Write = ifw;
      #1;
      check_all();
      @(posedge i_clk);
      model_edge();
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      #1;
      m_mode = M_IDLE; m_left = 0; m_count = 0; m_ack = 0;
      check_all();
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset = 0; i_cmd_run = 0; i_cmd_step = 0; i_cmd_stop = 0; i_cmd_clear = 0;
      i_HALT = 0; i_pc_Write = 1; i_IFID_Write = 1;
      m_mode = M_IDLE; m_left = 0; m_count = 0; m_ack = 0;

      // 1: reset, run, stop ten cycles later
      do_reset();
      cyc(.run(1));
      repeat (9) cyc();
      cyc(.stop(1));
      #1 chk("t1_count10", 64'(o_cycle_count), 64'd10);

      // 2: three single steps
      cyc(.clear(1));
      repeat (3) begin
         cyc(.step(1));
         repeat (4) cyc();
      end
      #1 chk("t2_count3", 64'(o_cycle_count), 64'd3);

      // 3: HALT in RUN, drain, park in DONE, run ignored, clear
      cyc(.run(1));
      repeat (3) cyc();
      cyc(.halt(1));
      repeat (DRAIN) cyc();
      #1 chk("t3_done", 64'(o_done), 64'd1);
      cyc(.run(1));
      cyc();
      cyc(.clear(1));
      cyc();

      // 4: hazard stall gating in RUN and in IDLE
      cyc(.run(1));
      repeat (3) cyc(.pcw(0), .ifw(0));
      cyc(.stop(1));
      repeat (2) cyc();

      // 5: coincident commands
      cyc(.run(1));
      cyc(.run(1), .stop(1));
      cyc();
      cyc(.run(1));
      cyc(.stop(1), .halt(1));
      repeat (DRAIN + 1) cyc(.stop(1));
      cyc(.clear(1));
      cyc(.step(1));
      cyc(.halt(1));
      repeat (DRAIN + 1) cyc();
      cyc(.clear(1));

      // 6: reset mid-run and mid-drain, then small-counter saturation
      cyc(.run(1));
      repeat (5) cyc();
      do_reset();
      cyc(.run(1));
      cyc(.halt(1));
      repeat (2) cyc();
      do_reset();
      cyc(.run(1));
      repeat (20) cyc();
      #1 chk("t6_sat15", 64'(s_cycle_count), 64'd15);
      cyc(.stop(1));

      // Randomized commands against the reference model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            cyc(.run($urandom_range(0, 7) == 0), .step($urandom_range(0, 7) == 0),
                .stop($urandom_range(0, 9) == 0), .clear($urandom_range(0, 9) == 0),
                .halt($urandom_range(0, 5) == 0),
                .pcw(1'($urandom_range(0, 1))), .ifw(1'($urandom_range(0, 1))));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
